conv_psum_accum_1x2: RTL and testbench

Accumulates the two 18-bit per-window convolution results from the dual-channel 3x3 kernel stage across all input-channel passes of a tile. Each pixel's partial sum is held in an on-chip psum buffer seeded with the per-channel bias. On the final pass it requantizes, applies leaky ReLU, saturates, and emits two int8 output-feature-map values per pixel. It sits directly downstream of the 1x2 conv kernel and upstream of the OFM writeback/pooling stage.

---
 rtl/conv_pkg.sv | 19 +
 rtl/conv_psum_accum_1x2_if.sv | 16 +
 rtl/psum_requant_int8.sv | 48 ++++
 rtl/conv_psum_accum_1x2.sv | 207 ++++++++++++++++++++
 tb/tb_conv_psum_accum_1x2.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared constants, FSM state type and sign-extension helper
// Purpose: widths and types shared by the psum accumulator, its interface and requant stage.
package conv_pkg;
   localparam int PSUM_W       = 32;
   localparam int OUT_W        = 8;
   localparam int LEAKY_SHIFT  = 3;
   localparam int KERNEL_OUT_W = 18;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      FLUSH = 2'd2
   } state_t;

   // Sign-extend an 18-bit kernel result to partial-sum width.
   function automatic logic [PSUM_W-1:0] sext_kernel(input logic [KERNEL_OUT_W-1:0] v);
      return {{(PSUM_W-KERNEL_OUT_W){v[KERNEL_OUT_W-1]}}, v};
   endfunction
endpackage

// File: rtl/conv_psum_accum_1x2_if.sv
// rtl/conv_psum_accum_1x2_if.sv - kernel-result input stream and int8 OFM output stream
// Ports: in_valid/in_ch1/in_ch2 (kernel side, no backpressure),
//        out_valid/out_ch1/out_ch2 (OFM writeback side).
interface conv_psum_accum_1x2_if
   import conv_pkg::*;
;
   logic                           in_valid;
   logic signed [KERNEL_OUT_W-1:0] in_ch1;
   logic signed [KERNEL_OUT_W-1:0] in_ch2;
   logic                           out_valid;
   logic signed [OUT_W-1:0]        out_ch1;
   logic signed [OUT_W-1:0]        out_ch2;

   modport master (output in_valid, in_ch1, in_ch2, input out_valid, out_ch1, out_ch2);
   modport slave  (input in_valid, in_ch1, in_ch2, output out_valid, out_ch1, out_ch2);
endinterface

// File: rtl/psum_requant_int8.sv
// rtl/psum_requant_int8.sv - round, arithmetic shift, optional leaky ReLU, int8 saturate
// Ports: clk, rst_n (async active-low), en (load output register), shift, leaky_en,
//        psum (signed partial sum), q (registered signed int8 result).
module psum_requant_int8
   import conv_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
   input  logic [4:0]               shift,
   input  logic                     leaky_en,
   input  logic signed [PSUM_W-1:0] psum,
   output logic signed [OUT_W-1:0]  q
);
   localparam logic signed [PSUM_W:0] Q_MAX = (PSUM_W+1)'((1 << (OUT_W-1)) - 1);
   localparam logic signed [PSUM_W:0] Q_MIN = ~Q_MAX;

   // One guard bit so the rounding add cannot overflow.
   logic signed [PSUM_W:0] ext;
   logic signed [PSUM_W:0] rnd;
   logic signed [PSUM_W:0] sum;
   logic signed [PSUM_W:0] r;
   logic signed [OUT_W-1:0] q_nx;

   always_comb begin
      ext = {psum[PSUM_W-1], psum};
      rnd = '0;
      if (shift != 5'd0)
         rnd = {{PSUM_W{1'b0}}, 1'b1} << (shift - 5'd1);
      sum = ext + rnd;
      r   = sum >>> shift;
      if (leaky_en && r[PSUM_W])
         r = r >>> LEAKY_SHIFT;
      if (r > Q_MAX)
         q_nx = Q_MAX[OUT_W-1:0];
      else if (r < Q_MIN)
         q_nx = Q_MIN[OUT_W-1:0];
      else
         q_nx = r[OUT_W-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         q <= '0;
      else if (en)
         q <= q_nx;
   end
endmodule

// File: rtl/conv_psum_accum_1x2.sv
// rtl/conv_psum_accum_1x2.sv - dual-channel psum accumulator with int8 requant output
// Ports: clk, rst_n (async active-low); cfg_start/cfg_pix_num/cfg_ch_num/cfg_shift/
//        cfg_leaky_en/bias_ch1/bias_ch2 (tile config, latched on start);
//        bus (slave: kernel results in, int8 OFM out); busy, done (tile status).
module conv_psum_accum_1x2
   import conv_pkg::*;
#(
   parameter int DEPTH  = 1024,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cfg_start,
   input  logic [ADDR_W:0]          cfg_pix_num,
   input  logic [9:0]               cfg_ch_num,
   input  logic [4:0]               cfg_shift,
   input  logic                     cfg_leaky_en,
   input  logic signed [PSUM_W-1:0] bias_ch1,
   input  logic signed [PSUM_W-1:0] bias_ch2,
   conv_psum_accum_1x2_if.slave     bus,
   output logic                     busy,
   output logic                     done
);
   localparam logic [ADDR_W:0] PIX_ONE = 1;

   state_t             state, state_nx;
   logic [1:0]         flush_cnt;
   logic               start_ok, accept, last_pix, last_ch, last_beat, done_set;

   logic [ADDR_W:0]    pix_num_q;
   logic [9:0]         ch_num_q;
   logic [4:0]         shift_q;
   logic               leaky_q;
   logic [PSUM_W-1:0]  bias1_q, bias2_q;
   logic [ADDR_W-1:0]  pix_cnt;
   logic [9:0]         ch_cnt;

   logic [2*PSUM_W-1:0] mem [DEPTH];
   logic [2*PSUM_W-1:0] rd_data;

   logic                    s1_valid, s1_first, s1_last;
   logic [ADDR_W-1:0]       s1_addr;
   logic [KERNEL_OUT_W-1:0] s1_in1, s1_in2;
   logic [PSUM_W-1:0]       base1, base2, sum1, sum2;
   logic                    s2_valid, s2_last, s2_wr;
   logic [ADDR_W-1:0]       s2_addr;
   logic [PSUM_W-1:0]       s2_sum1, s2_sum2;
   logic                    s3_valid;
   logic [ADDR_W-1:0]       s3_addr;
   logic [PSUM_W-1:0]       s3_sum1, s3_sum2;

   assign accept    = (state == ACCUM) && bus.in_valid;
   assign last_pix  = ({1'b0, pix_cnt} == (pix_num_q - PIX_ONE));
   assign last_ch   = (ch_cnt == (ch_num_q - 10'd1));
   assign last_beat = accept && last_pix && last_ch;

   // FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         flush_cnt <= 2'd0;
      end else begin
         state     <= state_nx;
         flush_cnt <= (state == FLUSH) ? flush_cnt + 2'd1 : 2'd0;
      end
   end

   // FSM: next state; FLUSH lasts three cycles so the last sum reaches out_valid.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (cfg_start) state_nx = ACCUM;
         ACCUM:   if (last_beat) state_nx = FLUSH;
         FLUSH:   if (flush_cnt == 2'd2) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      busy     = (state != IDLE);
      start_ok = (state == IDLE) && cfg_start;
      done_set = (state == FLUSH) && (flush_cnt == 2'd2);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done      <= 1'b0;
         pix_num_q <= '0;
         ch_num_q  <= '0;
         shift_q   <= '0;
         leaky_q   <= 1'b0;
         bias1_q   <= '0;
         bias2_q   <= '0;
         pix_cnt   <= '0;
         ch_cnt    <= '0;
      end else begin
         done <= done_set;
         if (start_ok) begin
            pix_num_q <= cfg_pix_num;
            ch_num_q  <= cfg_ch_num;
            shift_q   <= cfg_shift;
            leaky_q   <= cfg_leaky_en;
            bias1_q   <= bias_ch1;
            bias2_q   <= bias_ch2;
            pix_cnt   <= '0;
            ch_cnt    <= '0;
         end else if (accept) begin
            if (last_pix) begin
               pix_cnt <= '0;
               ch_cnt  <= ch_cnt + 10'd1;
            end else begin
               pix_cnt <= pix_cnt + 1'b1;
            end
         end
      end
   end

   // Psum buffer: ch2 in the upper half, ch1 in the lower half; read address is the
   // accepted beat's pixel, data returns one cycle later.
   always_ff @(posedge clk) begin
      if (s2_wr)
         mem[s2_addr] <= {s2_sum2, s2_sum1};
      rd_data <= mem[pix_cnt];
   end

   // Forwarding: s2 is written at the end of this cycle (RAM read missed it) and s3 was
   // written on the same edge as this beat's read, so both beat the RAM data.
   always_comb begin
      if (s1_first) begin
         base1 = bias1_q;
         base2 = bias2_q;
      end else if (s2_wr && (s2_addr == s1_addr)) begin
         base1 = s2_sum1;
         base2 = s2_sum2;
      end else if (s3_valid && (s3_addr == s1_addr)) begin
         base1 = s3_sum1;
         base2 = s3_sum2;
      end else begin
         base1 = rd_data[PSUM_W-1:0];
         base2 = rd_data[2*PSUM_W-1:PSUM_W];
      end
      sum1 = base1 + sext_kernel(s1_in1);
      sum2 = base2 + sext_kernel(s1_in2);
   end

   // Final pass is not written back; it only feeds requant.
   assign s2_wr = s2_valid && !s2_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid      <= 1'b0;
         s1_first      <= 1'b0;
         s1_last       <= 1'b0;
         s1_addr       <= '0;
         s1_in1        <= '0;
         s1_in2        <= '0;
         s2_valid      <= 1'b0;
         s2_last       <= 1'b0;
         s2_addr       <= '0;
         s2_sum1       <= '0;
         s2_sum2       <= '0;
         s3_valid      <= 1'b0;
         s3_addr       <= '0;
         s3_sum1       <= '0;
         s3_sum2       <= '0;
         bus.out_valid <= 1'b0;
      end else begin
         s1_valid      <= accept;
         s1_first      <= (ch_cnt == 10'd0);
         s1_last       <= last_ch;
         s1_addr       <= pix_cnt;
         s1_in1        <= bus.in_ch1;
         s1_in2        <= bus.in_ch2;
         s2_valid      <= s1_valid;
         s2_last       <= s1_last;
         s2_addr       <= s1_addr;
         s2_sum1       <= sum1;
         s2_sum2       <= sum2;
         s3_valid      <= s2_wr;
         s3_addr       <= s2_addr;
         s3_sum1       <= s2_sum1;
         s3_sum2       <= s2_sum2;
         bus.out_valid <= s2_valid && s2_last;
      end
   end

   psum_requant_int8 u_rq_ch1 (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (s2_valid && s2_last),
      .shift    (shift_q),
      .leaky_en (leaky_q),
      .psum     (s2_sum1),
      .q        (bus.out_ch1)
   );

   psum_requant_int8 u_rq_ch2 (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (s2_valid && s2_last),
      .shift    (shift_q),
      .leaky_en (leaky_q),
      .psum     (s2_sum2),
      .q        (bus.out_ch2)
   );
endmodule

// File: tb/tb_conv_psum_accum_1x2.sv
// tb/tb_conv_psum_accum_1x2.sv - directed self-checking bench for conv_psum_accum_1x2
module tb_conv_psum_accum_1x2;
   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               cfg_start = 1'b0;
   logic [10:0]        cfg_pix_num = '0;
   logic [9:0]         cfg_ch_num = '0;
   logic [4:0]         cfg_shift = '0;
   logic               cfg_leaky_en = 1'b0;
   logic signed [31:0] bias_ch1 = '0;
   logic signed [31:0] bias_ch2 = '0;
   logic               busy, done;

   conv_psum_accum_1x2_if bus ();

   conv_psum_accum_1x2 dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cfg_start    (cfg_start),
      .cfg_pix_num  (cfg_pix_num),
      .cfg_ch_num   (cfg_ch_num),
      .cfg_shift    (cfg_shift),
      .cfg_leaky_en (cfg_leaky_en),
      .bias_ch1     (bias_ch1),
      .bias_ch2     (bias_ch2),
      .bus          (bus),
      .busy         (busy),
      .done         (done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int oq1[$];
   int oq2[$];
   int ocyc[$];
   int done_cnt = 0;
   int done_cyc = 0;
   int lastk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.out_valid === 1'b1) begin
         oq1.push_back(int'($signed(bus.out_ch1)));
         oq2.push_back(int'($signed(bus.out_ch2)));
         ocyc.push_back(cyc);
      end
      if (done === 1'b1) begin
         done_cnt = done_cnt + 1;
         done_cyc = cyc;
      end
   end

   task automatic check(input string tag, input int observed, input int expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear();
      oq1.delete();
      oq2.delete();
      ocyc.delete();
      done_cnt = 0;
   endtask

   task automatic start(input int pix, input int ch, input int sh, input int lk,
                        input int b1, input int b2);
      cfg_pix_num  = pix[10:0];
      cfg_ch_num   = ch[9:0];
      cfg_shift    = sh[4:0];
      cfg_leaky_en = lk[0];
      bias_ch1     = b1;
      bias_ch2     = b2;
      cfg_start    = 1'b1;
      tick();
      cfg_start    = 1'b0;
   endtask

   task automatic beat(input int a, input int b);
      bus.in_valid = 1'b1;
      bus.in_ch1   = a[17:0];
      bus.in_ch2   = b[17:0];
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int maxc);
      int k = 0;
      while (done_cnt == 0 && k < maxc) begin
         tick();
         k++;
      end
      check(tag, done_cnt, 1);
   endtask

   task automatic check_outs(input string tag, input int n, input int e1 [], input int e2 []);
      check({tag, "_count"}, oq1.size(), n);
      for (int i = 0; i < n && i < oq1.size(); i++) begin
         check($sformatf("%s_ch1[%0d]", tag, i), oq1[i], e1[i]);
         check($sformatf("%s_ch2[%0d]", tag, i), oq2[i], e2[i]);
      end
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_ch1   = '0;
      bus.in_ch2   = '0;

      // reset state
      repeat (3) tick();
      check("rst_out_valid", int'(bus.out_valid), 0);
      check("rst_out_ch1", int'(bus.out_ch1), 0);
      check("rst_out_ch2", int'(bus.out_ch2), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      rst_n = 1'b1;
      tick();

      // single pass: bias + in, timing of last output and done
      clear();
      start(4, 1, 0, 0, 10, -10);
      check("t1_busy", int'(busy), 1);
      for (int i = 0; i < 4; i++) beat(5, 3);
      lastk = cyc;
      wait_done("t1_done", 20);
      check_outs("t1", 4, '{15, 15, 15, 15}, '{-7, -7, -7, -7});
      if (ocyc.size() == 4) check("t1_out_latency", ocyc[3], lastk + 2);
      check("t1_done_latency", done_cyc, lastk + 3);

      // three passes with rounding shift; no output before last pass
      clear();
      start(3, 3, 1, 0, 0, 0);
      for (int p = 0; p < 2; p++)
         for (int x = 0; x < 3; x++) beat(x + 1, -(x + 1));
      repeat (4) tick();
      check("t2_no_early_out", oq1.size(), 0);
      for (int x = 0; x < 3; x++) beat(x + 1, -(x + 1));
      wait_done("t2_done", 20);
      check_outs("t2", 3, '{2, 3, 5}, '{-1, -3, -4});

      // one pixel, eight back-to-back passes: forwarding, saturation, leaky
      clear();
      start(1, 8, 2, 1, 0, 0);
      for (int i = 0; i < 8; i++) beat(100, -100);
      wait_done("t3_done", 20);
      check_outs("t3", 1, '{127}, '{-25});

      // saturation at kernel extremes
      clear();
      start(2, 1, 0, 0, 0, 0);
      beat(131071, -131072);
      beat(-131072, 131071);
      wait_done("t4_done", 20);
      check_outs("t4", 2, '{127, -128}, '{-128, 127});

      // in_valid while idle ignored; cfg_start while busy ignored
      clear();
      for (int i = 0; i < 3; i++) beat(50, 50);
      repeat (5) tick();
      check("t6_idle_no_out", oq1.size(), 0);
      check("t6_idle_busy", int'(busy), 0);
      start(2, 2, 0, 0, 1, -1);
      beat(3, -4);
      cfg_pix_num  = 11'd1;
      cfg_ch_num   = 10'd1;
      cfg_shift    = 5'd3;
      cfg_leaky_en = 1'b1;
      bias_ch1     = 50;
      bias_ch2     = 50;
      cfg_start    = 1'b1;
      beat(3, -4);
      cfg_start    = 1'b0;
      beat(3, -4);
      beat(3, -4);
      wait_done("t6_done", 20);
      check_outs("t6", 2, '{7, 7}, '{-9, -9});

      // reset during pass 1, then rerun same tile uninterrupted
      clear();
      start(2, 3, 2, 1, 7, -3);
      beat(10, -20);
      beat(11, -19);
      beat(20, -40);
      rst_n = 1'b0;
      #2;
      check("t5_rst_out_valid", int'(bus.out_valid), 0);
      check("t5_rst_out_ch1", int'(bus.out_ch1), 0);
      check("t5_rst_out_ch2", int'(bus.out_ch2), 0);
      check("t5_rst_busy", int'(busy), 0);
      check("t5_rst_done", int'(done), 0);
      tick();
      rst_n = 1'b1;
      tick();
      clear();
      start(2, 3, 2, 1, 7, -3);
      for (int p = 0; p < 3; p++) begin
         beat(10 * (p + 1), -20 * (p + 1));
         beat(10 * (p + 1) + 1, -20 * (p + 1) + 1);
      end
      wait_done("t5_done", 20);
      check_outs("t5", 2, '{17, 18}, '{-4, -4});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
